serial_borrow_sub: RTL and testbench
====================================

// Module: serial_borrow_sub
// PURPOSE
// - Multi-cycle parametrised subtractor: computes diff = a - b - bin over WIDTH bits, SLICE bits per clock.
// - Internal ripple-borrow slice of full-subtractor cells; borrow is registered between slices.
// - Returns final borrow, signed-overflow and zero flags.
// - Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
// - Replaces wide single-cycle ripple-borrow chains where area or timing matters more than latency.
// PARAMETERS
// - WIDTH  8  operand/result width in bits; must be >= 2.
// - SLICE  1  bits processed per cycle; must divide WIDTH evenly (elaboration error otherwise).
// - STEPS      localparam = WIDTH/SLICE; number of RUN cycles per operation.
// PORTS
// - clk        in   1      single clock; all logic is on the rising edge.
// - rst        in   1      asynchronous, active-high reset.
// - in_valid   in   1      operand valid.
// - in_ready   out  1      block can accept operands.
// - a          in   WIDTH  minuend.
// - b          in   WIDTH  subtrahend.
// - bin        in   1      borrow-in.
// - out_valid  out  1      result valid.
// - out_ready  in   1      consumer accepts result.
// - diff       out  WIDTH  a - b - bin, modulo 2^WIDTH.
// - bout       out  1      final borrow; 1 when a < b + bin (unsigned).
// - ovf        out  1      signed overflow of a - b - bin (two's complement).
// - zero       out  1      1 when diff == 0.
// BEHAVIOUR
// - Reset
//   - On rst assertion, all state clears immediately, without waiting for a clock edge.
//   - The FSM returns to IDLE. in_ready=1 while in reset/IDLE.
//   - out_valid, diff, bout, ovf and zero are all 0.
//   - Reset mid-operation abandons the current operation; no partial result is ever presented.
// - FSM states: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: in_ready=1.
//     - On in_valid & in_ready: latch a and b into right-shift registers; borrow reg <= bin.
//     - Also latch a[WIDTH-1] and b[WIDTH-1]; clear the step counter; go to RUN.
//   - RUN: in_ready=0; lasts exactly STEPS cycles.
//     - Each cycle, the slice subtracts the low SLICE bits of the a/b shift regs with the borrow reg.
//     - Slice difference shifts into the diff register from the MSB side; borrow reg <= slice borrow-out.
//     - Shift regs shift right by SLICE; counter increments.
//     - When the counter reaches STEPS-1: go to DONE and register the flags.
//       - bout = final borrow.
//       - ovf = (a_msb ^ b_msb) & (a_msb ^ diff_msb).
//       - zero = ~|diff, evaluated on the completed diff.
//   - DONE: out_valid=1; diff, bout, ovf and zero are held stable.
//     - On out_ready=1, go to IDLE.
// - Latency: a handshake accepted on clock edge k gives out_valid=1 after edge k+STEPS.
//   - WIDTH=8, SLICE=1: 8 cycles. WIDTH=8, SLICE=4: 2 cycles.
// - Throughput: at most one operation per STEPS+2 cycles; operations never overlap.
// - Backpressure: while out_valid=1 and out_ready=0, all outputs hold and in_ready stays 0.
//   - in_valid asserted during RUN/DONE is ignored and nothing is captured.
// - Input stability: a, b and bin are sampled only on the accept edge; later changes have no effect.
// - Outputs are registered; diff/bout/ovf/zero are don't-care when out_valid=0 but must be 0 after reset.
// - Arithmetic is purely modulo 2^WIDTH with no saturation; bin is a true borrow-in for chaining words.
// STRUCTURE
// - Shared package sub_pkg holds:
//   - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 is illegal and recovers to IDLE);
//   - counter-width function clog2.
// - Sub-module sub_slice #(SLICE): purely combinational ripple-borrow chain.
//   - Ports: a, b (SLICE bits), bin -> d (SLICE bits), bout.
//   - Per bit: d = a^b^bin; bout = ~a&b | ~a&bin | b&bin.
//   - Instantiated once in serial_borrow_sub.
// TESTING
// - Basic (W=8, S=1): a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, ovf=0, zero=0.
//   - out_valid rises exactly 8 cycles after the accept edge.
// - Underflow: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0, zero=0.
// - Signed overflow: a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
//   - Also a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
// - Borrow-in and zero: a=0x10, b=0x0F, bin=1 -> diff=0x00, zero=1, bout=0, ovf=0.
// - Backpressure: hold out_ready=0 for 5 cycles in DONE.
//   - Outputs stay constant; a new in_valid is not accepted.
//   - Raise out_ready -> IDLE next cycle -> new operand accepted.
// - Reset / config:
//   - Assert rst on the 3rd RUN cycle -> out_valid=0 and in_ready=1 with no clock edge; the next operation is correct.
//   - Rerun with S=4 and with W=16, S=2, random operands vs a golden a-b-bin model; check latency STEPS.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the serial borrow subtractor: FSM state encoding
// and a constant-evaluable ceiling-log2 used to size the step counter.
package sub_pkg;

    // 2'd3 is not a legal state; the FSM recovers from it to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of bits needed to count 0 .. value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational ripple-borrow chain of SLICE full-subtractor cells.
// Bit 0 consumes the incoming borrow; the borrow out of the top bit is bout.
module sub_slice
    import sub_pkg::*;
#(
    parameter int SLICE = 1
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bin,
    output logic [SLICE-1:0] d,
    output logic             bout
);

    // Ripple the borrow from LSB to MSB through one full subtractor per bit.
    always_comb begin
        logic brw;
        d   = '0;
        brw = bin;
        for (int i = 0; i < SLICE; i++) begin
            d[i] = a[i] ^ b[i] ^ brw;
            brw  = (~a[i] & b[i]) | (~a[i] & brw) | (b[i] & brw);
        end
        bout = brw;
    end

endmodule

// File: rtl/serial_borrow_sub.sv
// Multi-cycle subtractor: diff = a - b - bin over WIDTH bits, SLICE bits per
// clock, with a registered borrow between slices. Operands arrive and results
// leave over valid/ready handshakes; one operation is in flight at a time.
module serial_borrow_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int STEPS = WIDTH / SLICE;
    localparam int CNT_W = (clog2(STEPS) < 1) ? 1 : clog2(STEPS);

    // Refuse to elaborate a configuration that cannot be sliced evenly.
    if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_param_check
        $error("serial_borrow_sub: WIDTH must be >= 2 and a multiple of SLICE");
    end

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               brw;
    logic               a_msb;
    logic               b_msb;
    logic [CNT_W-1:0]   cnt;
    logic [SLICE-1:0]   sl_d;
    logic               sl_bout;
    logic [WIDTH-1:0]   diff_next;
    logic               last_step;

    sub_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (a_sh[SLICE-1:0]),
        .b    (b_sh[SLICE-1:0]),
        .bin  (brw),
        .d    (sl_d),
        .bout (sl_bout)
    );

    // The new slice lands at the top of diff; after STEPS shifts the first
    // slice computed has walked down to bit 0.
    assign diff_next = WIDTH'({sl_d, diff} >> SLICE);
    assign last_step = (cnt == CNT_W'(STEPS - 1));

    // Control FSM together with the datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            brw       <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        brw      <= bin;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh <= a_sh >> SLICE;
                    b_sh <= b_sh >> SLICE;
                    brw  <= sl_bout;
                    diff <= diff_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_step) begin
                        bout      <= sl_bout;
                        ovf       <= (a_msb ^ b_msb) & (a_msb ^ diff_next[WIDTH-1]);
                        zero      <= ~|diff_next;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_borrow_sub.sv
// Self-checking bench for serial_borrow_sub. Three instances cover
// W=8/S=1, W=8/S=4 and W=16/S=2; results are compared against a plain
// arithmetic model of a - b - bin.
module tb_serial_borrow_sub;

    logic        clk;
    logic        rst;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [2:0]  bn;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  bo;
    logic [2:0]  of;
    logic [2:0]  zr;
    logic [7:0]  a0, b0, diff0;
    logic [7:0]  a1, b1, diff1;
    logic [15:0] a2, b2, diff2;

    int total;
    int bad;

    serial_borrow_sub #(.WIDTH(8), .SLICE(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a0), .b(b0), .bin(bn[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .diff(diff0), .bout(bo[0]), .ovf(of[0]), .zero(zr[0])
    );

    serial_borrow_sub #(.WIDTH(8), .SLICE(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a1), .b(b1), .bin(bn[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .diff(diff1), .bout(bo[1]), .ovf(of[1]), .zero(zr[1])
    );

    serial_borrow_sub #(.WIDTH(16), .SLICE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a2), .b(b2), .bin(bn[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .diff(diff2), .bout(bo[2]), .ovf(of[2]), .zero(zr[2])
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    function automatic int width_of(input int idx);
        return (idx == 2) ? 16 : 8;
    endfunction

    function automatic int steps_of(input int idx);
        case (idx)
            0:       return 8;
            1:       return 2;
            default: return 8;
        endcase
    endfunction

    function automatic logic [15:0] get_diff(input int idx);
        case (idx)
            0:       return {8'h00, diff0};
            1:       return {8'h00, diff1};
            default: return diff2;
        endcase
    endfunction

    task automatic set_ops(input int idx, input logic [15:0] a, input logic [15:0] b);
        case (idx)
            0:       begin a0 = a[7:0]; b0 = b[7:0]; end
            1:       begin a1 = a[7:0]; b1 = b[7:0]; end
            default: begin a2 = a;      b2 = b;      end
        endcase
    endtask

    // Golden model: integer arithmetic on unsigned and signed readings.
    task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic bi, output logic [15:0] ed, output logic eb,
                         output logic eo, output logic ez);
        longint mask, half, ua, ub, sa, sb, full, sres;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        full = ua - ub - longint'(bi);
        ed   = 16'(full & mask);
        eb   = (full < 0);
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        sres = sa - sb - longint'(bi);
        eo   = (sres < -half) || (sres >= half);
        ez   = ((full & mask) == 0);
    endtask

    // One full operation on instance idx: accept, latency, result, optional
    // backpressure (with in_valid poked during DONE), release.
    task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input logic bi, input int hold, input logic poke);
        int          steps;
        int          cyc;
        logic [15:0] ed;
        logic        eb, eo, ez;
        steps = steps_of(idx);
        model(width_of(idx), a, b, bi, ed, eb, eo, ez);

        @(negedge clk);
        total++;
        if (ir[idx] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL in_ready_idle dut%0d got=%b exp=1", idx, ir[idx]);
        end
        set_ops(idx, a, b);
        bn[idx] = bi;
        iv[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[idx] = 1'b0;
        set_ops(idx, ~a, a ^ 16'h5a5a);
        bn[idx] = ~bi;
        total++;
        if (ir[idx] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL in_ready_busy dut%0d got=%b exp=0", idx, ir[idx]);
        end

        cyc = 0;
        while (ov[idx] !== 1'b1 && cyc < steps + 4) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        total++;
        if (ov[idx] !== 1'b1 || cyc != steps) begin
            bad++;
            $display("[TB] FAIL latency dut%0d got=%0d exp=%0d out_valid=%b", idx, cyc, steps, ov[idx]);
            return;
        end

        total++;
        if (get_diff(idx) !== ed) begin
            bad++;
            $display("[TB] FAIL diff dut%0d a=%h b=%h bin=%b got=%h exp=%h", idx, a, b, bi, get_diff(idx), ed);
        end
        total++;
        if ({bo[idx], of[idx], zr[idx]} !== {eb, eo, ez}) begin
            bad++;
            $display("[TB] FAIL flags dut%0d a=%h b=%h bin=%b got bout/ovf/zero=%b%b%b exp=%b%b%b",
                     idx, a, b, bi, bo[idx], of[idx], zr[idx], eb, eo, ez);
        end

        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                set_ops(idx, 16'(h * 37 + 1), 16'(h * 11 + 3));
                iv[idx] = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            total++;
            if ({ov[idx], ir[idx], get_diff(idx), bo[idx], of[idx], zr[idx]} !== {2'b10, ed, eb, eo, ez}) begin
                bad++;
                $display("[TB] FAIL hold dut%0d cycle=%0d got v/r=%b%b diff=%h got flags=%b%b%b exp diff=%h",
                         idx, h, ov[idx], ir[idx], get_diff(idx), bo[idx], of[idx], zr[idx], ed);
            end
        end
        iv[idx] = 1'b0;

        ordy[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[idx] = 1'b0;
        total++;
        if ({ov[idx], ir[idx]} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL release dut%0d got v/r=%b%b exp=01", idx, ov[idx], ir[idx]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({ir, ov} !== 6'b111_000) begin
            bad++;
            $display("[TB] FAIL reset_hs got ready=%b valid=%b exp=111/000", ir, ov);
        end
        total++;
        if ({diff0, diff1, diff2, bo, of, zr} !== 41'd0) begin
            bad++;
            $display("[TB] FAIL reset_out got d0=%h d1=%h d2=%h b=%b o=%b z=%b exp=0", diff0, diff1, diff2, bo, of, zr);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(0, 16'h05, 16'h03, 1'b0, 0, 1'b0);
        run_op(0, 16'h00, 16'h01, 1'b0, 0, 1'b0);
        run_op(0, 16'h80, 16'h01, 1'b0, 0, 1'b0);
        run_op(0, 16'h7F, 16'hFF, 1'b0, 0, 1'b0);
        run_op(0, 16'h10, 16'h0F, 1'b1, 0, 1'b0);
        run_op(0, 16'h00, 16'h00, 1'b1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_op(0, 16'h3C, 16'h5A, 1'b1, 5, 1'b1);
        run_op(0, 16'hA7, 16'h21, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        a0 = 8'h9C;
        b0 = 8'h33;
        bn[0] = 1'b0;
        iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({ov[0], ir[0], diff0} !== {2'b01, 8'h00}) begin
            bad++;
            $display("[TB] FAIL reset_mid got v/r=%b%b diff=%h exp=01 00", ov[0], ir[0], diff0);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 16'h42, 16'h17, 1'b1, 0, 1'b0);
    endtask

    task automatic test_random(input int idx, input int n);
        logic [15:0] ra, rb;
        for (int k = 0; k < n; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(idx, ra, rb, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end
    endtask

    initial begin
        clk   = 1'b0;
        rst   = 1'b0;
        iv    = '0;
        ordy  = '0;
        bn    = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        total = 0;
        bad   = 0;
        #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random(0, 10);
        test_random(1, 15);
        test_random(2, 15);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
